// File: rtl/lock_pkg.sv
// Shared state encoding and gate_status codes for the code-entry display path.
package lock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ENTRY = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  localparam logic [2:0] GATE_IDLE    = 3'd2;
  localparam logic [2:0] GATE_ENTRY_A = 3'd3;
  localparam logic [2:0] GATE_ENTRY_B = 3'd4;
  localparam logic [2:0] GATE_ENTRY_C = 3'd5;

  function automatic logic gate_permits_entry(input logic [2:0] gate);
    return (gate == GATE_ENTRY_A) || (gate == GATE_ENTRY_B) || (gate == GATE_ENTRY_C);
  endfunction

endpackage

// File: rtl/blink_divider.sv
// Free-running blink counter; its MSB sets the cursor blink phase.
// Only present in builds with CODE_ENTRY_BLINK_EN defined.
`ifdef CODE_ENTRY_BLINK_EN
module blink_divider #(
  parameter int WIDTH = 24
) (
  input  logic clk,
  input  logic rst_n,
  output logic blink
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + WIDTH'(1);
    end
  end

  assign blink = count_reg[WIDTH-1];

endmodule
`endif

// File: rtl/code_entry_buffer.sv
// Keypad code-entry buffer: IDLE/ENTRY/FULL slot store with append, overwrite and backspace.
// Optional cursor blink output enabled by defining CODE_ENTRY_BLINK_EN.
module code_entry_buffer
  import lock_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DIGIT_W    = 4,
  parameter logic [NUM_DIGITS*DIGIT_W-1:0] IDLE_PATTERN = 16'hC15D,
  parameter int BLINK_DIV  = 24
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [2:0]                        gate_status,
  input  logic [DIGIT_W-1:0]                digit_in,
  input  logic                              digit_valid,
  input  logic [$clog2(NUM_DIGITS)-1:0]     index_in,
  input  logic                              index_wr,
  input  logic                              backspace,
  output logic [NUM_DIGITS*DIGIT_W-1:0]     display_out,
  output logic [$clog2(NUM_DIGITS+1)-1:0]   digit_count,
  output logic                              entry_full,
  output logic [NUM_DIGITS-1:0]             blank_mask,
  output logic                              overflow_err,
  output logic [NUM_DIGITS-1:0]             blink_mask
);

  localparam int IDX_W  = $clog2(NUM_DIGITS);
  localparam int CNT_W  = $clog2(NUM_DIGITS + 1);
  localparam int DISP_W = NUM_DIGITS * DIGIT_W;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_DIGITS - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  state_t              state_reg, state_next;
  logic [DISP_W-1:0]   display_reg, display_next;
  logic [CNT_W-1:0]    count_reg, count_next;
  logic [IDX_W-1:0]    cursor_reg, cursor_next;
  logic [NUM_DIGITS-1:0] blank_reg, blank_next;
  logic                overflow_reg, overflow_next;

  // Single slot update per cycle: the winning strobe selects slot, data and blank flag.
  logic                slot_we;
  logic [IDX_W-1:0]    slot_idx;
  logic [DIGIT_W-1:0]  slot_data;
  logic                slot_blank;

  always_comb begin
    state_next    = state_reg;
    display_next  = display_reg;
    count_next    = count_reg;
    cursor_next   = cursor_reg;
    blank_next    = blank_reg;
    overflow_next = 1'b0;
    slot_we       = 1'b0;
    slot_idx      = '0;
    slot_data     = '0;
    slot_blank    = 1'b0;

    if (gate_status == GATE_IDLE) begin
      state_next   = ST_IDLE;
      display_next = IDLE_PATTERN;
      count_next   = '0;
      cursor_next  = '0;
      blank_next   = '0;
    end else if (gate_permits_entry(gate_status)) begin
      case (state_reg)
        ST_IDLE: begin
          state_next   = ST_ENTRY;
          display_next = '0;
          count_next   = '0;
          cursor_next  = '0;
          blank_next   = '1;
        end
        ST_ENTRY, ST_FULL: begin
          if (backspace) begin
            if (count_reg != '0) begin
              slot_we     = 1'b1;
              slot_idx    = IDX_W'(count_reg - CNT_W'(1));
              slot_blank  = 1'b1;
              count_next  = count_reg - CNT_W'(1);
              cursor_next = IDX_W'(count_reg - CNT_W'(1));
              state_next  = ST_ENTRY;
            end
          end else if (digit_valid) begin
            if (state_reg == ST_FULL) begin
              overflow_next = 1'b1;
            end else begin
              slot_we    = 1'b1;
              slot_idx   = cursor_reg;
              slot_data  = digit_in;
              count_next = count_reg + CNT_W'(1);
              if (count_reg == LAST_CNT) begin
                state_next  = ST_FULL;
                cursor_next = LAST_IDX;
              end else begin
                cursor_next = cursor_reg + IDX_W'(1);
              end
            end
          end else if (index_wr && (CNT_W'(index_in) < count_reg)) begin
            slot_we   = 1'b1;
            slot_idx  = index_in;
            slot_data = digit_in;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end

    if (slot_we) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (slot_idx == IDX_W'(i)) begin
          display_next[(NUM_DIGITS-1-i)*DIGIT_W +: DIGIT_W] = slot_data;
          blank_next[NUM_DIGITS-1-i] = slot_blank;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      display_reg  <= IDLE_PATTERN;
      count_reg    <= '0;
      cursor_reg   <= '0;
      blank_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      display_reg  <= display_next;
      count_reg    <= count_next;
      cursor_reg   <= cursor_next;
      blank_reg    <= blank_next;
      overflow_reg <= overflow_next;
    end
  end

  assign display_out  = display_reg;
  assign digit_count  = count_reg;
  assign entry_full   = (state_reg == ST_FULL);
  assign blank_mask   = blank_reg;
  assign overflow_err = overflow_reg;

`ifdef CODE_ENTRY_BLINK_EN
  logic                  blink_phase;
  logic [NUM_DIGITS-1:0] blink_reg, blink_next;

  blink_divider #(
    .WIDTH (BLINK_DIV)
  ) u_blink_divider (
    .clk   (clk),
    .rst_n (rst_n),
    .blink (blink_phase)
  );

  always_comb begin
    blink_next = '0;
    if (state_next == ST_ENTRY) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (cursor_next == IDX_W'(i)) begin
          blink_next[NUM_DIGITS-1-i] = blink_phase;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_reg <= '0;
    end else begin
      blink_reg <= blink_next;
    end
  end

  assign blink_mask = blink_reg;
`else
  logic unused_blink_cfg;
  assign unused_blink_cfg = (BLINK_DIV != 0);
  assign blink_mask = '0;
`endif

endmodule
